edge_bbox: RTL
==============

# edge_bbox

Frame-level statistics stage placed directly downstream of the Sobel/threshold pipeline. It consumes the binary edge stream (`{3{0 or 255}}` pixels) with the same `en`/`hsync`/`vsync` framing and tracks raster coordinates. Per frame, it accumulates the edge-pixel count and the bounding box of all edge pixels. At frame end it publishes the result through a valid/ack handshake for the downstream detection logic.

## Interface
- `COORD_BITS`, 11: width of x/y counters and bbox outputs (frames up to 2048x2048).
- `COUNT_BITS`, 22: width of the edge-pixel counter.
- `MIN_COUNT`, 16: minimum edge count for `found`.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-low reset. When 0, all state is cleared immediately.
- `en` in 1: pixel qualifier, same meaning as in the upstream pipeline.
- `hsync` in 1: high during horizontal blanking.
- `vsync` in 1: high during vertical blanking.
- `data` in `PIXEL_SIZE`: thresholded pixel. The pixel is an edge iff `data[7:0] != 0`.
- `out_valid` out 1: frame result available.
- `out_ack` in 1: consumer accepts the result.
- `x_min`, `x_max`, `y_min`, `y_max` out `COORD_BITS` each: bounding box, inclusive.
- `count` out `COUNT_BITS`: number of edge pixels in the frame.
- `found` out 1: `count >= MIN_COUNT`.
- `overrun` out 1: a result was overwritten before it was acked.

## Operation
- **Accepted pixel:** `en=1`, `hsync=0`, `vsync=0`, and FSM in ACTIVE. Nothing else is accumulated.
- **Edge detection:** `hsync_d` and `vsync_d` are registered copies of the syncs, used for rising-edge detection.
- **FSM states:**
  - WAIT_FRAME (reset state): ignores pixels. On a vsync falling edge (`vsync=0`, `vsync_d=1`), clears the accumulators and x/y, then moves to ACTIVE.
  - ACTIVE: accumulates. On a vsync rising edge, moves to PUBLISH.
  - PUBLISH: lasts exactly one cycle. Loads the output registers, clears the accumulators and x/y, then moves to WAIT_FRAME.
- **Coordinates:**
  - `x` increments after each accepted pixel.
  - On an hsync rising edge: `x <= 0`, and `y <= y+1` only if `x != 0`. Empty lines therefore do not advance `y`.
  - `x` and `y` saturate at `2^COORD_BITS-1`; they never wrap.
- **Accumulators:** on an accepted edge pixel at (x,y):
  - `count` increments, saturating at `2^COUNT_BITS-1`.
  - `x_min`/`x_max`/`y_min`/`y_max` update by unsigned compare.
  - Min registers initialise to all-ones, max registers to 0.
- **Publish:**
  - If `count == 0`: all four bbox outputs are 0 and `found=0`.
  - Otherwise the accumulated values are loaded and `found = (count >= MIN_COUNT)`.
- **Handshake:**
  - `out_valid` is set by PUBLISH and held until a cycle with `out_ack=1`.
  - Output fields are stable while `out_valid=1`, unless overwritten by the next PUBLISH.
  - `out_ack` while `out_valid=0` is ignored.
- **Overrun:**
  - PUBLISH while `out_valid=1` and `out_ack=0`: new data overwrites the old, `out_valid` stays 1, `overrun <= 1`.
  - PUBLISH and `out_ack` in the same cycle: new data loads, `out_valid` stays 1, `overrun` unchanged.
  - `overrun` clears on an accepted ack (`out_valid & out_ack`) that is not simultaneous with a PUBLISH.

## Timing
- **Reset values:** every output and internal register is 0, except the min accumulators (all-ones). FSM = WAIT_FRAME.
- **Publish latency:** vsync first sampled high at edge N → FSM = PUBLISH after edge N → outputs and `out_valid` update at edge N+1.
- **Pixel timing:** a pixel presented together with the first high vsync is not accumulated.
- **Ack timing:** `out_valid` falls on the edge that samples `out_ack=1`.
- **Reset mid-frame or mid-handshake:** partial results are discarded and `out_valid` drops asynchronously. The next result requires a full vsync fall-to-rise frame.
- **Syncs:** `hsync` and `vsync` asserted together → the vsync rule takes priority. The hsync edge in that cycle is still registered, so no spurious edge is seen later.
- **Throughput:** one pixel per cycle, no stalls. The block never backpressures the pixel stream.

## Test plan
- **Basic frame:** `MIN_COUNT=2`, vsync low, frame of 4 lines x 8 pixels, edges at (2,1) and (5,3), then vsync high → two cycles later: `out_valid=1`, bbox (2,5,1,3), `count=2`, `found=1`, `overrun=0`.
- **Empty frame:** all-zero pixels → `count=0`, all bbox fields 0, `found=0`. Same frame but with `en=0` on the edge pixels → identical result.
- **Back-to-back frames, no ack:** two frames, no ack → second result visible and `overrun=1`. Then ack → `out_valid=0` and `overrun=0` on the next edge.
- **Simultaneous ack and publish:** `out_ack=1` in the PUBLISH cycle → new data loaded, `out_valid=1`, `overrun=0`.
- **Reset mid-frame:** `reset=0` mid-frame after 5 edge pixels → all outputs 0 immediately. A following full frame with a single edge at (0,0) yields bbox (0,0,0,0) and `count=1`.
- **Saturation:** `COORD_BITS=3`, line of 12 pixels with the last pixel an edge → `x_min=x_max=7`. `COUNT_BITS=3` with 10 edges → `count=7`.

Source files
------------

// File: rtl/edge_bbox.sv
// edge_bbox: per-frame edge statistics on a thresholded pixel stream.
// Counts edge pixels and tracks the bounding box of all edges in raster
// coordinates, then publishes the result at frame end over a valid/ack port.
//
// Result handshake: out_valid rises on the cycle after PUBLISH and stays
// high until a clock edge samples out_ack=1 while out_valid=1. Result fields
// hold steady while out_valid=1 unless a newer PUBLISH overwrites them. An
// overwrite of an unacked result sets overrun. out_ack while out_valid=0 has
// no effect.
module edge_bbox #(
    parameter int COORD_BITS = 11,
    parameter int COUNT_BITS = 22,
    parameter int MIN_COUNT  = 16,
    parameter int PIXEL_SIZE = 24
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  hsync,
    input  logic                  vsync,
    input  logic [PIXEL_SIZE-1:0] data,
    output logic                  out_valid,
    input  logic                  out_ack,
    output logic [COORD_BITS-1:0] x_min,
    output logic [COORD_BITS-1:0] x_max,
    output logic [COORD_BITS-1:0] y_min,
    output logic [COORD_BITS-1:0] y_max,
    output logic [COUNT_BITS-1:0] count,
    output logic                  found,
    output logic                  overrun,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        ACTIVE     = 2'd1,
        PUBLISH    = 2'd2
    } state_t;

    localparam logic [COORD_BITS-1:0] C_MAX = '1;
    localparam logic [COUNT_BITS-1:0] K_MAX = '1;
    localparam logic [COUNT_BITS:0]   MIN_W = (COUNT_BITS+1)'(MIN_COUNT);

    state_t state, state_nxt;

    logic hsync_d, vsync_d;
    logic hsync_rise, vsync_rise, vsync_fall;
    logic accept, is_edge, clear_acc;

    logic [COORD_BITS-1:0] x, y;
    logic [COORD_BITS-1:0] acc_xmin, acc_xmax, acc_ymin, acc_ymax;
    logic [COUNT_BITS-1:0] acc_count;

    // Only the low byte decides edge-ness; the rest of the pixel is ignored.
    logic unused_data;
    assign unused_data = ^data;

    assign hsync_rise = hsync & ~hsync_d;
    assign vsync_rise = vsync & ~vsync_d;
    assign vsync_fall = ~vsync & vsync_d;
    assign accept     = en & ~hsync & ~vsync & (state == ACTIVE);
    assign is_edge    = (data[7:0] != 8'd0);
    assign clear_acc  = ((state == WAIT_FRAME) && vsync_fall) || (state == PUBLISH);
    assign dbg_state  = state;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= WAIT_FRAME;
        else        state <= state_nxt;
    end

    // Next-state: frame opens on vsync fall, closes on vsync rise, publish is one cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            WAIT_FRAME: if (vsync_fall) state_nxt = ACTIVE;
            ACTIVE:     if (vsync_rise) state_nxt = PUBLISH;
            PUBLISH:    state_nxt = WAIT_FRAME;
            default:    state_nxt = WAIT_FRAME;
        endcase
    end

    // Registered syncs for edge detection, updated every cycle regardless of state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hsync_d <= 1'b0;
            vsync_d <= 1'b0;
        end else begin
            hsync_d <= hsync;
            vsync_d <= vsync;
        end
    end

    // Raster coordinates and accumulators; vsync rise outranks a same-cycle hsync rise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x         <= '0;
            y         <= '0;
            acc_count <= '0;
            acc_xmin  <= '1;
            acc_xmax  <= '0;
            acc_ymin  <= '1;
            acc_ymax  <= '0;
        end else if (clear_acc) begin
            x         <= '0;
            y         <= '0;
            acc_count <= '0;
            acc_xmin  <= '1;
            acc_xmax  <= '0;
            acc_ymin  <= '1;
            acc_ymax  <= '0;
        end else if ((state == ACTIVE) && !vsync_rise) begin
            if (hsync_rise) begin
                x <= '0;
                // Empty lines leave y alone.
                if ((x != '0) && (y != C_MAX)) y <= y + COORD_BITS'(1);
            end else if (accept) begin
                if (x != C_MAX) x <= x + COORD_BITS'(1);
                if (is_edge) begin
                    if (acc_count != K_MAX) acc_count <= acc_count + COUNT_BITS'(1);
                    if (x < acc_xmin) acc_xmin <= x;
                    if (x > acc_xmax) acc_xmax <= x;
                    if (y < acc_ymin) acc_ymin <= y;
                    if (y > acc_ymax) acc_ymax <= y;
                end
            end
        end
    end

    // Result registers, valid and overrun flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            overrun   <= 1'b0;
            x_min     <= '0;
            x_max     <= '0;
            y_min     <= '0;
            y_max     <= '0;
            count     <= '0;
            found     <= 1'b0;
        end else if (state == PUBLISH) begin
            out_valid <= 1'b1;
            if (out_valid && !out_ack) overrun <= 1'b1;
            count <= acc_count;
            if (acc_count == '0) begin
                x_min <= '0;
                x_max <= '0;
                y_min <= '0;
                y_max <= '0;
                found <= 1'b0;
            end else begin
                x_min <= acc_xmin;
                x_max <= acc_xmax;
                y_min <= acc_ymin;
                y_max <= acc_ymax;
                found <= ({1'b0, acc_count} >= MIN_W);
            end
        end else if (out_valid && out_ack) begin
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end
    end

endmodule
